// File: rtl/fsm_d_pkg.sv
// Shared types for the two-road traffic-light controller.
package fsm_d_pkg;

  // Lamp codes as seen by the lamp drivers; 2'b11 is never produced.
  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  // S0: A green, S1: A yellow, S2: B green, S3: B yellow.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam int YELLOW_CYCLES_DEFAULT = 1;

  // True for the two yellow phases, which are the only timed states.
  function automatic logic is_yellow(input state_t s);
    return (s == S1) || (s == S3);
  endfunction

endpackage

// File: rtl/fsm_d_yellow_timer.sv
// Counts the length of a yellow phase and flags its last cycle.
module fsm_d_yellow_timer #(
  parameter int YELLOW_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic enable,
  output logic done
);

  localparam int W = $clog2(YELLOW_CYCLES) + 1;
  localparam logic [W-1:0] LAST = W'(YELLOW_CYCLES - 1);

  logic [W-1:0] count;

  // Count while a yellow phase is active; sit at zero otherwise so every phase starts fresh.
  always_ff @(posedge clk) begin
    if (rst || start || !enable || done) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign done = enable && (count == LAST);

endmodule

// File: rtl/fsm_d.sv
// Harris-style two-road traffic-light controller (Moore machine).
module fsm_d
  import fsm_d_pkg::*;
#(
  parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb
);

  state_t state;
  state_t next_state;
  light_t la_light;
  light_t lb_light;
  logic   yellow_start;
  logic   yellow_active;
  logic   yellow_done;

  assign yellow_active = is_yellow(state);
  assign yellow_start  = !is_yellow(state) && is_yellow(next_state);

  fsm_d_yellow_timer #(
    .YELLOW_CYCLES(YELLOW_CYCLES)
  ) u_yellow_timer (
    .clk   (clk),
    .rst   (rst),
    .start (yellow_start),
    .enable(yellow_active),
    .done  (yellow_done)
  );

  // State register; reset wins over every transition, including mid-yellow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an unknown sensor falls into the else branch so the encoding stays legal.
  always_comb begin
    next_state = S0;
    case (state)
      S0: begin
        if (ta) next_state = S0;
        else    next_state = S1;
      end
      S1: begin
        if (yellow_done) next_state = S2;
        else             next_state = S1;
      end
      S2: begin
        if (tb) next_state = S2;
        else    next_state = S3;
      end
      S3: begin
        if (yellow_done) next_state = S0;
        else             next_state = S3;
      end
      default: next_state = S0;
    endcase
  end

  // Output decode purely from state; at least one street always sees RED.
  always_comb begin
    la_light = RED;
    lb_light = RED;
    case (state)
      S0: begin la_light = GREEN;  lb_light = RED;    end
      S1: begin la_light = YELLOW; lb_light = RED;    end
      S2: begin la_light = RED;    lb_light = GREEN;  end
      S3: begin la_light = RED;    lb_light = YELLOW; end
      default: begin la_light = RED; lb_light = RED; end
    endcase
  end

  assign la = la_light;
  assign lb = lb_light;

endmodule

// File: tb/tb_fsm_d.sv
// Scoreboard bench for fsm_d: one instance with 1-cycle yellow, one with 3-cycle yellow.
module tb_fsm_d;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;

  typedef struct {
    logic       chk3;
    logic [1:0] la;
    logic [1:0] lb;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ta;
  logic       tb;
  logic [1:0] la1, lb1, la3, lb3;

  exp_t sb[$];
  int   n_compared;
  int   n_mismatched;
  bit   active;

  fsm_d #(.YELLOW_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ta(ta), .tb(tb), .la(la1), .lb(lb1)
  );

  fsm_d #(.YELLOW_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ta(ta), .tb(tb), .la(la3), .lb(lb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue what the selected DUT must show after the next rising edge.
  task automatic applyStimulus(input logic r, input logic a, input logic b,
                               input logic chk3, input logic [1:0] ela,
                               input logic [1:0] elb, input string name);
    exp_t e;
    @(negedge clk);
    rst = r;
    ta  = a;
    tb  = b;
    e.chk3 = chk3;
    e.la   = ela;
    e.lb   = elb;
    e.name = name;
    sb.push_back(e);
    active = 1'b1;
    @(posedge clk);
  endtask

  // Compare one observed light pair with the expectation popped from the scoreboard.
  task automatic checkOutput(input exp_t e, input logic [1:0] ala, input logic [1:0] alb);
    n_compared++;
    if (ala !== e.la || alb !== e.lb) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got la=%b lb=%b, expected la=%b lb=%b",
               e.name, ala, alb, e.la, e.lb);
    end
  endtask

  // Monitor: after each rising edge pop one expectation and check the safety invariant on both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.chk3) checkOutput(e, la3, lb3);
          else        checkOutput(e, la1, lb1);
        end
        n_compared++;
        if ((la1 != R && lb1 != R) || (la3 != R && lb3 != R) ||
            la1 == 2'b11 || lb1 == 2'b11 || la3 == 2'b11 || lb3 == 2'b11) begin
          n_mismatched++;
          $display("[TB] FAIL safety: la1=%b lb1=%b la3=%b lb3=%b", la1, lb1, la3, lb3);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ta  = 1'b0;
    tb  = 1'b0;
    active = 1'b0;
    n_compared = 0;
    n_mismatched = 0;

    // Reset with unknown sensors, then release with traffic on A.
    applyStimulus(1'b1, 1'bx, 1'bx, 1'b0, G, R, "reset_1");
    applyStimulus(1'b1, 1'bx, 1'bx, 1'b0, G, R, "reset_2");
    applyStimulus(1'b0, 1'b1, 1'bx, 1'b0, G, R, "hold_a_1");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, G, R, "hold_a_2");

    // A-to-B handover, B held while tb=1.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, Y, R, "a_yellow");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, R, G, "b_green");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, R, G, "hold_b_1");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, R, G, "hold_b_2");

    // B-to-A handover, then A held while ta=1.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, R, Y, "b_yellow");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, G, R, "a_green");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, G, R, "hold_a_3");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, G, R, "hold_a_4");

    // Free run with no traffic: S1,S2,S3,S0 twice.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, Y, R, "free_s1");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, R, G, "free_s2");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, R, Y, "free_s3");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, G, R, "free_s0");
    end

    // Reset from S1 and from S2; sensors toggling under reset change nothing.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, Y, R, "pre_rst_s1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, G, R, "rst_from_s1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, G, R, "rst_toggle_1");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, G, R, "rst_toggle_2");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, Y, R, "post_rst_s1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, R, G, "pre_rst_s2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, G, R, "rst_from_s2");

    // Three-cycle yellow instance: restart from reset and walk a full cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, G, R, "y3_reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, Y, R, "y3_a_yellow");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, R, G, "y3_b_green");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, R, G, "y3_hold_b");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, R, Y, "y3_b_yellow");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, G, R, "y3_a_green");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, G, R, "y3_hold_a");

    // Reset mid-yellow must also clear the yellow counter.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, Y, R, "y3_mid_1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, Y, R, "y3_mid_2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, G, R, "y3_rst_mid");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, Y, R, "y3_after_rst");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, R, G, "y3_after_rst_b");

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
